cpu_io_port: RTL and testbench

Parametrised, memory-mapped I/O port peripheral for the cpu. It is the multi-channel successor of the single fixed 8-bit output `port`.
- Sits on the cpu data bus (addr_w/data_w/we write side, addr_r/data_r read side).
- Provides CHANNELS ports of WIDTH bits, each with output latch, per-bit direction, synchronised input sampling and rising-edge capture.
- Drives pins directly; an optional interrupt output goes to the cpu.

---
 rtl/cpu_io_pkg.sv | 23 ++
 rtl/cpu_io_port_if.sv | 30 +++
 rtl/io_sync_edge.sv | 32 +++
 rtl/cpu_io_port.sv | 141 ++++++++++++++
 tb/tb_cpu_io_port.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_io_pkg.sv
// Shared constants for cpu_io_port: per-channel register offsets, register stride
// and the edge-capture arm limit.
package cpu_io_pkg;

  localparam int unsigned REG_STRIDE = 4;

  localparam logic [1:0] OFS_OUT  = 2'd0;
  localparam logic [1:0] OFS_DIR  = 2'd1;
  localparam logic [1:0] OFS_IN   = 2'd2;
  localparam logic [1:0] OFS_EDGE = 2'd3;

  localparam logic [1:0] ARM_MAX = 2'd3;

  typedef enum logic [1:0] {
    REG_OUT  = OFS_OUT,
    REG_DIR  = OFS_DIR,
    REG_IN   = OFS_IN,
    REG_EDGE = OFS_EDGE
  } reg_ofs_e;

  typedef logic [1:0] arm_cnt_t;

endpackage

// File: rtl/cpu_io_port_if.sv
// cpu data-bus view of cpu_io_port: write side (addr_w/data_w/we) and
// registered read side (addr_r/data_r).
interface cpu_io_port_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WIDTH  = 8
);

  logic [ADDR_W-1:0] addr_w;
  logic [WIDTH-1:0]  data_w;
  logic              we;
  logic [ADDR_W-1:0] addr_r;
  logic [WIDTH-1:0]  data_r;

  modport master (
    output addr_w,
    output data_w,
    output we,
    output addr_r,
    input  data_r
  );

  modport slave (
    input  addr_w,
    input  data_w,
    input  we,
    input  addr_r,
    output data_r
  );

endinterface

// File: rtl/io_sync_edge.sv
// Per-channel input path: two-flop synchroniser for asynchronous pins, a
// previous-sample register and the resulting rising-edge vector.
module io_sync_edge #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_pin,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_sync = r_sync2;
  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/cpu_io_port.sv
// Memory-mapped multi-channel I/O port: OUT/DIR/IN/EDGE registers per channel.
// Define CPU_IO_PORT_IRQ_EN to build the rising-edge flags, arm counter and irq.
module cpu_io_port
  import cpu_io_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       CHANNELS  = 2,
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hF0
) (
  input  logic                      clk,
  input  logic                      reset,
  cpu_io_port_if.slave              bus,
  input  logic [CHANNELS*WIDTH-1:0] pin_in,
  output logic [CHANNELS*WIDTH-1:0] pin_out,
  output logic [CHANNELS*WIDTH-1:0] pin_oe,
  output logic                      irq
);

  logic [CHANNELS-1:0][WIDTH-1:0] w_ch_rd;
  logic [WIDTH-1:0][CHANNELS-1:0] w_rd_tr;
  logic [WIDTH-1:0]               w_rd;

`ifdef CPU_IO_PORT_IRQ_EN
  logic [CHANNELS-1:0] w_ch_flag;
  arm_cnt_t            r_arm;
  logic                w_armed;
  logic                r_irq;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [ADDR_W-1:0] CH_BASE = BASE_ADDR + ADDR_W'(REG_STRIDE * c);

    logic [ADDR_W-1:0] w_wofs;
    logic [ADDR_W-1:0] w_rofs;
    logic              w_wsel;
    logic              w_rsel;
    reg_ofs_e          w_wreg;
    reg_ofs_e          w_rreg;
    logic [WIDTH-1:0]  r_out;
    logic [WIDTH-1:0]  r_dir;
    logic [WIDTH-1:0]  w_in;
    logic [WIDTH-1:0]  w_rise;
    logic [WIDTH-1:0]  w_flag;

    // Distance from the channel base over the full address width; addresses
    // below the base wrap to large values and fall outside the 4-entry slot.
    assign w_wofs = bus.addr_w - CH_BASE;
    assign w_rofs = bus.addr_r - CH_BASE;
    assign w_wsel = bus.we && (w_wofs < ADDR_W'(REG_STRIDE));
    assign w_rsel = (w_rofs < ADDR_W'(REG_STRIDE));
    assign w_wreg = reg_ofs_e'(w_wofs[1:0]);
    assign w_rreg = reg_ofs_e'(w_rofs[1:0]);

    io_sync_edge #(
      .WIDTH (WIDTH)
    ) u_sync (
      .i_clk  (clk),
      .i_rst  (reset),
      .i_pin  (pin_in[c*WIDTH +: WIDTH]),
      .o_sync (w_in),
      .o_rise (w_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_out <= '0;
        r_dir <= '0;
      end else begin
        if (w_wsel && (w_wreg == REG_OUT)) r_out <= bus.data_w;
        if (w_wsel && (w_wreg == REG_DIR)) r_dir <= bus.data_w;
      end
    end

`ifdef CPU_IO_PORT_IRQ_EN
    logic [WIDTH-1:0] r_flag;
    logic [WIDTH-1:0] w_clr;

    assign w_clr = (w_wsel && (w_wreg == REG_EDGE)) ? bus.data_w : '0;

    // OR-ing the rise in after the clear lets a new edge win over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_flag <= '0;
      else       r_flag <= (r_flag & ~w_clr) | (w_rise & {WIDTH{w_armed}});
    end

    assign w_flag       = r_flag;
    assign w_ch_flag[c] = |r_flag;
`else
    logic w_unused_rise;
    assign w_unused_rise = ^w_rise;
    assign w_flag        = '0;
`endif

    always_comb begin
      w_ch_rd[c] = '0;
      if (w_rsel) begin
        case (w_rreg)
          REG_OUT:  w_ch_rd[c] = r_out;
          REG_DIR:  w_ch_rd[c] = r_dir;
          REG_IN:   w_ch_rd[c] = w_in;
          REG_EDGE: w_ch_rd[c] = w_flag;
        endcase
      end
    end

    assign pin_out[c*WIDTH +: WIDTH] = r_out;
    assign pin_oe[c*WIDTH +: WIDTH]  = r_dir;
  end

  // At most one channel selects a non-zero value, so the read mux is a per-bit OR.
  for (genvar b = 0; b < WIDTH; b++) begin : g_rd_bit
    for (genvar c = 0; c < CHANNELS; c++) begin : g_rd_ch
      assign w_rd_tr[b][c] = w_ch_rd[c][b];
    end
    assign w_rd[b] = |w_rd_tr[b];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.data_r <= '0;
    else       bus.data_r <= w_rd;
  end

`ifdef CPU_IO_PORT_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arm <= '0;
      r_irq <= 1'b0;
    end else begin
      if (r_arm != ARM_MAX) r_arm <= r_arm + 2'd1;
      r_irq <= |w_ch_flag;
    end
  end

  assign w_armed = (r_arm == ARM_MAX);
  assign irq     = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_io_port.sv
// Self-checking bench for cpu_io_port: directed vector table, hand sequences for
// latency/edge/reset corners, and random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_cpu_io_port;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned PW       = WIDTH * CHANNELS;
  localparam logic [7:0]  BASE     = 8'hF0;
`ifdef CPU_IO_PORT_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] pin_in;
  logic [PW-1:0] pin_out;
  logic [PW-1:0] pin_oe;
  logic          irq;

  cpu_io_port_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) bus ();

  cpu_io_port #(
    .WIDTH     (WIDTH),
    .CHANNELS  (CHANNELS),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: register contents plus a history of sampled pin values
  // (newest first); IN is the value seen two edges ago.
  logic [WIDTH-1:0] m_out  [CHANNELS];
  logic [WIDTH-1:0] m_dir  [CHANNELS];
  logic [WIDTH-1:0] m_edge [CHANNELS];
  logic [PW-1:0]    m_hist [$];
  int unsigned      m_edges;
  logic [WIDTH-1:0] m_data_r;
  logic             m_irq;

  typedef struct {
    logic        we;
    logic [7:0]  aw;
    logic [7:0]  dw;
    logic [7:0]  ar;
    logic [7:0]  exp_rd;
    logic [15:0] exp_out;
    logic [15:0] exp_oe;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [7:0] a);
    return (32'(a) >= 32'(BASE)) && (32'(a) < 32'(BASE) + 4 * CHANNELS);
  endfunction

  function automatic logic [WIDTH-1:0] m_read(input logic [7:0] a);
    int unsigned   rel;
    logic [PW-1:0] in_all;
    if (!in_window(a)) return '0;
    rel    = 32'(a) - 32'(BASE);
    in_all = m_hist[1];
    case (rel % 4)
      0:       return m_out[rel / 4];
      1:       return m_dir[rel / 4];
      2:       return in_all[(rel / 4) * WIDTH +: WIDTH];
      default: return IRQ_EN ? m_edge[rel / 4] : '0;
    endcase
  endfunction

  function automatic logic [PW-1:0] m_pins(input bit oe);
    logic [PW-1:0] r = '0;
    for (int c = 0; c < CHANNELS; c++) r[c*WIDTH +: WIDTH] = oe ? m_dir[c] : m_out[c];
    return r;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_out[c]  = '0;
      m_dir[c]  = '0;
      m_edge[c] = '0;
    end
    m_hist = {};
    for (int i = 0; i < 3; i++) m_hist.push_back('0);
    m_edges  = 0;
    m_data_r = '0;
    m_irq    = 1'b0;
  endtask

  task automatic m_step();
    logic [PW-1:0] rise;
    int unsigned   rel;
    m_data_r = m_read(bus.addr_r);
    m_irq    = 1'b0;
    if (IRQ_EN) for (int c = 0; c < CHANNELS; c++) m_irq |= |m_edge[c];
    rise = m_hist[1] & ~m_hist[2];
    if (bus.we && in_window(bus.addr_w)) begin
      rel = 32'(bus.addr_w) - 32'(BASE);
      case (rel % 4)
        0:       m_out[rel / 4] = bus.data_w;
        1:       m_dir[rel / 4] = bus.data_w;
        3:       m_edge[rel / 4] = m_edge[rel / 4] & ~bus.data_w;
        default: ;
      endcase
    end
    // Edges are taken only from the fourth clock after reset release onwards.
    if (IRQ_EN && m_edges >= 3)
      for (int c = 0; c < CHANNELS; c++) m_edge[c] |= rise[c*WIDTH +: WIDTH];
    m_hist.push_front(pin_in);
    void'(m_hist.pop_back());
    m_edges++;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) m_reset();
    else       m_step();
    #1;
    check("model_pin_out", 32'(pin_out), 32'(m_pins(1'b0)));
    check("model_pin_oe",  32'(pin_oe),  32'(m_pins(1'b1)));
    check("model_data_r",  32'(bus.data_r), 32'(m_data_r));
    check("model_irq",     32'(irq), 32'(m_irq));
  endtask

  task automatic drive(input logic we, input logic [7:0] aw, input logic [7:0] dw,
                       input logic [7:0] ar);
    bus.we     = we;
    bus.addr_w = aw;
    bus.data_w = dw;
    bus.addr_r = ar;
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 9) < 8) return BASE + 8'($urandom_range(0, 8));
    return 8'($urandom);
  endfunction

  initial begin
    tbl = '{
      '{1'b1, 8'hF0, 8'hA5, 8'hF0, 8'h00, 16'h00A5, 16'h0000},
      '{1'b1, 8'hF1, 8'hFF, 8'hF0, 8'hA5, 16'h00A5, 16'h00FF},
      '{1'b1, 8'hF8, 8'h55, 8'hF1, 8'hFF, 16'h00A5, 16'h00FF},
      '{1'b1, 8'hEF, 8'h55, 8'hF8, 8'h00, 16'h00A5, 16'h00FF},
      '{1'b1, 8'hF6, 8'h77, 8'hEF, 8'h00, 16'h00A5, 16'h00FF},
      '{1'b1, 8'hF4, 8'h3C, 8'hF6, 8'h00, 16'h3CA5, 16'h00FF},
      '{1'b1, 8'hF5, 8'h0F, 8'hF4, 8'h3C, 16'h3CA5, 16'h0FFF},
      '{1'b0, 8'hF4, 8'h00, 8'hF5, 8'h0F, 16'h3CA5, 16'h0FFF},
      '{1'b1, 8'hF0, 8'h11, 8'hF0, 8'hA5, 16'h3C11, 16'h0FFF},
      '{1'b0, 8'hF0, 8'h00, 8'hF0, 8'h11, 16'h3C11, 16'h0FFF},
      '{1'b1, 8'hF7, 8'hFF, 8'hF7, 8'h00, 16'h3C11, 16'h0FFF},
      '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 16'h3C11, 16'h0FFF}
    };

    // Reset with all pins high; no edge may be captured after release.
    reset  = 1'b1;
    pin_in = '1;
    drive(1'b0, 8'h00, 8'h00, 8'hF3);
    m_reset();
    repeat (4) cycle();
    check("rst_pin_out", 32'(pin_out), 32'h0);
    check("rst_pin_oe",  32'(pin_oe),  32'h0);
    check("rst_data_r",  32'(bus.data_r), 32'h0);
    check("rst_irq",     32'(irq), 32'h0);
    reset = 1'b0;
    repeat (8) cycle();
    check("rst_edge_ch0", 32'(bus.data_r), 32'h0);
    check("rst_irq_after", 32'(irq), 32'h0);
    bus.addr_r = 8'hF7;
    repeat (2) cycle();
    check("rst_edge_ch1", 32'(bus.data_r), 32'h0);
    pin_in = '0;
    repeat (4) cycle();

    // Directed vectors: output/direction writes, decode boundaries, read-during-write.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].we, tbl[i].aw, tbl[i].dw, tbl[i].ar);
      cycle();
      check($sformatf("tbl%0d_rd", i),  32'(bus.data_r), 32'(tbl[i].exp_rd));
      check($sformatf("tbl%0d_out", i), 32'(pin_out), 32'(tbl[i].exp_out));
      check($sformatf("tbl%0d_oe", i),  32'(pin_oe),  32'(tbl[i].exp_oe));
    end

    // Input latency: channel 1 pins to data_r through IN takes three edges.
    drive(1'b0, 8'h00, 8'h00, 8'hF6);
    pin_in = 16'h3C00;
    cycle();
    check("lat_c1", 32'(bus.data_r), 32'h00);
    cycle();
    check("lat_c2", 32'(bus.data_r), 32'h00);
    cycle();
    check("lat_c3", 32'(bus.data_r), 32'h3C);
    repeat (2) cycle();
    drive(1'b1, 8'hF7, 8'hFF, 8'hF3);
    cycle();
    drive(1'b1, 8'hF3, 8'hFF, 8'hF3);
    cycle();
    drive(1'b0, 8'h00, 8'h00, 8'hF3);
    repeat (2) cycle();
    check("pre_edge_irq", 32'(irq), 32'h0);

`ifdef CPU_IO_PORT_IRQ_EN
    // Rising edge on pin 0: flag two edges after sampling, irq one edge later.
    pin_in = 16'h3C01;
    repeat (3) cycle();
    check("edge_irq_not_yet", 32'(irq), 32'h0);
    cycle();
    check("edge_flag_set", 32'(bus.data_r), 32'h01);
    check("edge_irq_set",  32'(irq), 32'h1);
    drive(1'b1, 8'hF3, 8'h01, 8'hF3);
    cycle();
    check("clr_irq_still", 32'(irq), 32'h1);
    drive(1'b0, 8'h00, 8'h00, 8'hF3);
    cycle();
    check("clr_irq_fall", 32'(irq), 32'h0);
    check("clr_flag",     32'(bus.data_r), 32'h00);
    // Clear of bit 1 lands on the same edge that captures its rise.
    pin_in = 16'h3C03;
    repeat (2) cycle();
    drive(1'b1, 8'hF3, 8'h02, 8'hF3);
    cycle();
    drive(1'b0, 8'h00, 8'h00, 8'hF3);
    cycle();
    check("coincide_bit1", 32'(bus.data_r), 32'h02);
    check("coincide_irq",  32'(irq), 32'h1);
`else
    pin_in = 16'h3C01;
    repeat (6) cycle();
    check("noirq_edge_reads0", 32'(bus.data_r), 32'h0);
    check("noirq_irq0",        32'(irq), 32'h0);
    drive(1'b1, 8'hF3, 8'hFF, 8'hF3);
    cycle();
    drive(1'b0, 8'h00, 8'h00, 8'hF3);
    cycle();
    check("noirq_edge_write_ignored", 32'(bus.data_r), 32'h0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), rand_addr(), 8'($urandom), rand_addr());
      if ($urandom_range(0, 3) == 0) pin_in = 16'($urandom);
      cycle();
    end

    // Mid-cycle asynchronous reset with OUT = FF and an edge flag pending.
    pin_in = '0;
    drive(1'b1, 8'hF0, 8'hFF, 8'hF3);
    cycle();
    drive(1'b1, 8'hF3, 8'hFF, 8'hF3);
    cycle();
    drive(1'b1, 8'hF7, 8'hFF, 8'hF3);
    cycle();
    drive(1'b0, 8'h00, 8'h00, 8'hF3);
    repeat (3) cycle();
    pin_in = 16'h0001;
    repeat (4) cycle();
    check("mid_pin_out_ff", 32'(pin_out[7:0]), 32'hFF);
`ifdef CPU_IO_PORT_IRQ_EN
    check("mid_irq_pending", 32'(irq), 32'h1);
`endif
    #3;
    reset = 1'b1;
    #1;
    check("async_pin_out", 32'(pin_out), 32'h0);
    check("async_pin_oe",  32'(pin_oe),  32'h0);
    check("async_irq",     32'(irq), 32'h0);
    check("async_data_r",  32'(bus.data_r), 32'h0);
    m_reset();
    pin_in = '0;
    cycle();
    reset = 1'b0;
    repeat (2) cycle();
    check("async_edge_cleared", 32'(bus.data_r), 32'h0);
    check("async_irq_low",      32'(irq), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
